// File: rtl/spi_dac_rx.sv
// spi_dac_rx: MCP49x1-style SPI DAC receiver with a small memory-mapped
// status/control window. SPI pins are synchronized into clk and sampled
// on their synchronized edges; frames land in an input register and move
// to the output register on an LDAC falling edge (or immediately while
// LDAC is held low).
// Optional feature: define SPI_DAC_RX_ERRCNT_EN to keep an 8-bit saturating
// count of rejected frames (read in word 2 bits [7:0]).
module spi_dac_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        cs,
    input  logic        scl,
    input  logic        sdi,
    input  logic        ldac,
    output logic [11:0] dac_out,
    output logic        gain_x2,
    output logic        buf_en,
    output logic        active,
    output logic        update
);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Pin order inside the synchronizer: {cs, scl, sdi, ldac}; idle levels 1,0,0,1.
    localparam logic [3:0]  PIN_IDLE  = 4'b1001;
    localparam logic [2:0]  EDGE_IDLE = 3'b101;  // {cs, scl, ldac}
    localparam logic [15:0] REG_RST   = 16'h7000;
    localparam int          SETTLE_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]          pins_s;
    logic [2:0]          prev_q;
    logic [SETTLE_W-1:0] settle_q;
    logic                settled;
    logic                cs_rise, cs_fall, scl_rise, ldac_fall, sdi_s, ldac_s;

    state_t      state_q, state_d;
    logic        start, shift_en, frame_end, frame_ok, clr;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] in_q, in_d;
    logic [15:0] out_q, out_d;
    logic        upd_q, upd_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_view;
    logic        ready_q;
    logic [31:0] rdata_q, rd_mux;
    logic        unused_bus;

    // Synchronize the SPI pins and hold off edge detection until the chain
    // and the edge flops carry real pin levels after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q   <= {SYNC_STAGES{PIN_IDLE}};
            prev_q   <= EDGE_IDLE;
            settle_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], {cs, scl, sdi, ldac}};
            prev_q   <= {pins_s[3], pins_s[2], pins_s[0]};
            if (!settled)
                settle_q <= settle_q + SETTLE_W'(1);
        end
    end

    assign pins_s    = sync_q[SYNC_STAGES-1];
    assign settled   = (settle_q == SETTLE_DONE);
    assign sdi_s     = pins_s[1];
    assign ldac_s    = pins_s[0];
    assign cs_rise   = settled &  pins_s[3] & ~prev_q[2];
    assign cs_fall   = settled & ~pins_s[3] &  prev_q[2];
    assign scl_rise  = settled &  pins_s[2] & ~prev_q[1];
    assign ldac_fall = settled & ~pins_s[0] &  prev_q[0];

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Frame FSM next state: a cs falling edge opens a frame, a rising edge always closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame FSM outputs: clear on frame start, shift on scl rise, evaluate on frame end.
    always_comb begin
        start     = 1'b0;
        shift_en  = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE:  start = cs_fall;
            SHIFT: begin
                frame_end = cs_rise;
                shift_en  = scl_rise & ~cs_rise;
            end
            default: ;
        endcase
    end

    assign frame_ok = frame_end && (cnt_q == 5'd16) && !shreg_q[15];
    assign clr      = valid && (addr[3:2] == 2'd3) && (|wstrb);

    // Next-state for shifter, DAC registers, update pulse and frame counter.
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        in_d        = in_q;
        out_d       = out_q;
        upd_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (start) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (shift_en) begin
            shreg_d = {shreg_q[14:0], sdi_s};
            if (cnt_q != 5'd17)
                cnt_d = cnt_q + 5'd1;
        end
        if (frame_ok)
            in_d = shreg_q;
        // LDAC held low makes the output register follow each accepted frame;
        // a coincident LDAC edge therefore also picks up the new frame.
        if (frame_ok && !ldac_s) begin
            out_d = shreg_q;
            upd_d = 1'b1;
        end else if (ldac_fall) begin
            out_d = in_q;
            upd_d = 1'b1;
        end
        if (clr)
            frame_cnt_d = '0;
        else if (frame_ok)
            frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Datapath and counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            in_q        <= REG_RST;
            out_q       <= REG_RST;
            upd_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            in_q        <= in_d;
            out_q       <= out_d;
            upd_q       <= upd_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef SPI_DAC_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_frame;

    assign err_frame = frame_end & ~frame_ok;

    // Saturating count of rejected frames; a clear request takes priority.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr)
            err_cnt_d = '0;
        else if (err_frame && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (!resetn) err_cnt_q <= '0;
        else         err_cnt_q <= err_cnt_d;
    end

    assign err_view = err_cnt_q;
`else
    assign err_view = 8'h00;
`endif

    // Read mux, word-decoded on addr[3:2].
    always_comb begin
        rd_mux = 32'h0;
        case (addr[3:2])
            2'd0:    rd_mux = {16'h0, in_q};
            2'd1:    rd_mux = {16'h0, out_q};
            2'd2:    rd_mux = {frame_cnt_q, 8'h00, err_view};
            default: rd_mux = 32'h0;
        endcase
    end

    // Bus acknowledge one cycle after the request, with registered read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= valid;
            rdata_q <= valid ? rd_mux : 32'h0;
        end
    end

    assign unused_bus = ^{addr[31:4], addr[1:0], wdata};

    assign ready   = ready_q;
    assign rdata   = rdata_q;
    assign update  = upd_q;
    assign dac_out = out_q[12] ? out_q[11:0] : 12'h000;
    assign gain_x2 = ~out_q[13];
    assign buf_en  = out_q[14];
    assign active  = out_q[12];

endmodule

// File: tb/tb_spi_dac_rx.sv
// Directed bench for spi_dac_rx: a table of SPI frames with expected register
// and pin results, then hand-written sequences for reset, mid-frame reset
// and counter-clear corner cases.
`timescale 1ns/1ps

module tb_spi_dac_rx;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] addr = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        cs = 1'b1;
    logic        scl = 1'b0;
    logic        sdi = 1'b0;
    logic        ldac = 1'b1;
    logic [11:0] dac_out;
    logic        gain_x2, buf_en, active, update;

    spi_dac_rx dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready),
        .addr(addr), .wstrb(wstrb), .wdata(wdata), .rdata(rdata),
        .cs(cs), .scl(scl), .sdi(sdi), .ldac(ldac),
        .dac_out(dac_out), .gain_x2(gain_x2), .buf_en(buf_en),
        .active(active), .update(update)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // mode: 0 = frame only, 1 = ldac pulse after the frame, 2 = ldac held low
    typedef struct {
        logic [15:0] data;
        int          nbits;
        int          mode;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [11:0] dac;
        logic        gain;
        logic        bufe;
        logic        act;
        logic [15:0] fc;
        logic [7:0]  err;
        int          upds;
    } vec_t;

    vec_t tab[8];

    // Update pulses and input-register changes, observed on the falling edge.
    int          cyc = 0;
    int          upd_cnt = 0;
    int          upd_cyc = -1;
    int          in_cyc = -2;
    logic [15:0] in_prev = 16'h7000;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (update === 1'b1) begin
            upd_cnt = upd_cnt + 1;
            upd_cyc = cyc;
        end
        if (dut.in_q !== in_prev) begin
            in_cyc  = cyc;
            in_prev = dut.in_q;
        end
    end

    function automatic logic [7:0] errx(input logic [7:0] v);
`ifdef SPI_DAC_RX_ERRCNT_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [15:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = (i < 16) ? data[i] : 1'b0;
            wait_clk(4);
            scl = 1'b1;
            wait_clk(4);
            scl = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [15:0] data, input int nbits);
        cs = 1'b0;
        wait_clk(4);
        spi_bits(data, nbits);
        wait_clk(4);
        cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic ldac_pulse();
        ldac = 1'b0;
        wait_clk(4);
        ldac = 1'b1;
        wait_clk(6);
    endtask

    task automatic bus_read(input logic [1:0] w, output logic [31:0] d);
        @(negedge clk);
        valid = 1'b1;
        addr  = {28'h0, w, 2'b00};
        wstrb = 4'h0;
        @(negedge clk);
        d     = rdata;
        valid = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] w, input logic [3:0] strb, input logic [31:0] d);
        @(negedge clk);
        valid = 1'b1;
        addr  = {28'h0, w, 2'b00};
        wstrb = strb;
        wdata = d;
        @(negedge clk);
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    logic [31:0] rd;
    int          ub;

    initial begin
        // 3123 and 6FFF have bit13 (GA) set, so gain_x2 is 0 for them; 1123 clears it.
        tab[0] = '{16'h7ABC, 16, 1, 16'h7ABC, 16'h7ABC, 12'hABC, 1'b0, 1'b1, 1'b1, 16'd1, 8'd0, 1};
        tab[1] = '{16'h3123, 16, 2, 16'h3123, 16'h3123, 12'h123, 1'b0, 1'b0, 1'b1, 16'd2, 8'd0, 1};
        tab[2] = '{16'h1234, 15, 0, 16'h3123, 16'h3123, 12'h123, 1'b0, 1'b0, 1'b1, 16'd2, 8'd1, 0};
        tab[3] = '{16'h2345, 17, 0, 16'h3123, 16'h3123, 12'h123, 1'b0, 1'b0, 1'b1, 16'd2, 8'd2, 0};
        tab[4] = '{16'hF555, 16, 0, 16'h3123, 16'h3123, 12'h123, 1'b0, 1'b0, 1'b1, 16'd2, 8'd3, 0};
        tab[5] = '{16'h6FFF, 16, 1, 16'h6FFF, 16'h6FFF, 12'h000, 1'b0, 1'b1, 1'b0, 16'd3, 8'd3, 1};
        tab[6] = '{16'h1123, 16, 1, 16'h1123, 16'h1123, 12'h123, 1'b1, 1'b0, 1'b1, 16'd4, 8'd3, 1};
        tab[7] = '{16'h8000, 16, 1, 16'h1123, 16'h1123, 12'h123, 1'b1, 1'b0, 1'b1, 16'd4, 8'd4, 1};

        // Reset values, sampled while reset is held.
        wait_clk(5);
        check("rst_ready",   {31'h0, ready},   32'h0);
        check("rst_rdata",   rdata,            32'h0);
        check("rst_update",  {31'h0, update},  32'h0);
        check("rst_dac_out", {20'h0, dac_out}, 32'h0);
        check("rst_gain_x2", {31'h0, gain_x2}, 32'h0);
        check("rst_buf_en",  {31'h0, buf_en},  32'h1);
        check("rst_active",  {31'h0, active},  32'h1);
        resetn = 1'b1;
        wait_clk(10);

        // Bus handshake: ready follows valid by one cycle.
        @(negedge clk);
        valid = 1'b1;
        addr  = 32'h0;
        @(negedge clk);
        check("ready_high", {31'h0, ready}, 32'h1);
        check("rst_word0",  rdata,          32'h0000_7000);
        valid = 1'b0;
        @(negedge clk);
        check("ready_low",  {31'h0, ready}, 32'h0);
        bus_read(2'd1, rd); check("rst_word1", rd, 32'h0000_7000);
        bus_read(2'd2, rd); check("rst_word2", rd, 32'h0);
        bus_read(2'd3, rd); check("rst_word3", rd, 32'h0);

        // Frame table.
        for (int k = 0; k < 8; k++) begin
            if (tab[k].mode == 2) begin
                ldac = 1'b0;
                wait_clk(10);
            end
            ub = upd_cnt;
            spi_frame(tab[k].data, tab[k].nbits);
            if (tab[k].mode == 1)
                ldac_pulse();
            if (tab[k].mode == 2) begin
                check($sformatf("v%0d_upd_same_cycle", k), upd_cyc, in_cyc);
                ldac = 1'b1;
                wait_clk(10);
            end
            check($sformatf("v%0d_updates", k), upd_cnt - ub, tab[k].upds);
            check($sformatf("v%0d_dac_out", k), {20'h0, dac_out}, {20'h0, tab[k].dac});
            check($sformatf("v%0d_gain_x2", k), {31'h0, gain_x2}, {31'h0, tab[k].gain});
            check($sformatf("v%0d_buf_en", k),  {31'h0, buf_en},  {31'h0, tab[k].bufe});
            check($sformatf("v%0d_active", k),  {31'h0, active},  {31'h0, tab[k].act});
            bus_read(2'd0, rd); check($sformatf("v%0d_word0", k), rd, {16'h0, tab[k].w0});
            bus_read(2'd1, rd); check($sformatf("v%0d_word1", k), rd, {16'h0, tab[k].w1});
            bus_read(2'd2, rd);
            check($sformatf("v%0d_word2", k), rd, {tab[k].fc, 8'h00, errx(tab[k].err)});
        end

        // Reset in the middle of a frame, released with cs still low.
        cs = 1'b0;
        wait_clk(4);
        spi_bits(16'hA5A5, 8);
        resetn = 1'b0;
        wait_clk(4);
        resetn = 1'b1;
        wait_clk(12);
        cs = 1'b1;
        wait_clk(8);
        bus_read(2'd2, rd); check("midrst_word2_before", rd, 32'h0);
        ub = upd_cnt;
        spi_frame(16'h7001, 16);
        ldac_pulse();
        check("midrst_dac_out", {20'h0, dac_out}, 32'h001);
        check("midrst_updates", upd_cnt - ub, 1);
        bus_read(2'd0, rd); check("midrst_word0", rd, 32'h0000_7001);
        bus_read(2'd2, rd); check("midrst_word2", rd, 32'h0001_0000);

        // Clear request in the same cycle the frame is accepted: clear wins.
        cs = 1'b0;
        wait_clk(4);
        spi_bits(16'h7555, 16);
        wait_clk(4);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        valid = 1'b1;
        addr  = 32'hC;
        wstrb = 4'hF;
        @(negedge clk);
        valid = 1'b0;
        wstrb = 4'h0;
        wait_clk(8);
        bus_read(2'd0, rd); check("clrwin_word0", rd, 32'h0000_7555);
        bus_read(2'd2, rd); check("clrwin_word2", rd, 32'h0);

        // Writes to word 0 and strobe-less writes to word 3 have no effect.
        spi_frame(16'h7002, 16);
        bus_write(2'd0, 4'hF, 32'hFFFF_FFFF);
        bus_read(2'd0, rd); check("wr_word0_ignored", rd, 32'h0000_7002);
        bus_write(2'd3, 4'h0, 32'h0);
        bus_read(2'd2, rd); check("wr_nostrb_noclr", rd, 32'h0001_0000);
        bus_write(2'd3, 4'h1, 32'h0);
        bus_read(2'd2, rd); check("wr_strb_clr", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
